// File: rtl/spi_display_pkg.sv
// Shared types for the SPI display target.
// Used by the target top and its receive FIFO.
package spi_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } spi_state_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } rx_entry_t;

    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_display_if.sv
// SPI display link pins: initiator drives clock, data,
// select and D/C; the target returns miso.
interface spi_display_if;

    logic spi_clk;
    logic spi_mosi;
    logic display_csb;
    logic data_commandb;
    logic spi_miso;

    modport master (
        output spi_clk,
        output spi_mosi,
        output display_csb,
        output data_commandb,
        input  spi_miso
    );

    modport slave (
        input  spi_clk,
        input  spi_mosi,
        input  display_csb,
        input  data_commandb,
        output spi_miso
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/full and valid/ready pop.
// A push into a full FIFO is dropped unless a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             drop,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_fire;
    logic             accept;

    assign pop_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_fire  = pop_valid & pop_ready;
    assign accept    = push & (~full | pop_fire);
    assign drop      = push & full & ~pop_fire;
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({accept, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // When full with a pop, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_display_target.sv
// SPI mode-0 target for the display link: oversampled on clk,
// bytes tagged with D/C go to a FIFO, tx bytes return on miso.
module spi_display_target
    import spi_display_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_display_if.slave spi,
    output logic [7:0]   rx_data,
    output logic         rx_dc,
    output logic         rx_valid,
    input  logic         rx_ready,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         overflow,
    output logic         frame_error
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] csb_q;
    logic [SYNC_STAGES-1:0] dc_q;
    logic sclk_d;
    logic csb_d;
    logic sclk_s;
    logic mosi_s;
    logic csb_s;
    logic dc_s;
    logic rise;
    logic fall;
    logic csb_fall;
    logic csb_rise;

    spi_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       skip_fall, skip_fall_n;
    logic       push_q, push_n;
    rx_entry_t  push_entry, push_entry_n;
    logic       ferr_n;
    logic       load;

    rx_entry_t  head;
    logic       fifo_full;
    logic       fifo_drop;

    // Sync chains reset low so a csb held low through rst
    // never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            mosi_q <= '0;
            csb_q  <= '0;
            dc_q   <= '0;
            sclk_d <= 1'b0;
            csb_d  <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi.spi_clk};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi};
            csb_q  <= {csb_q[SYNC_STAGES-2:0], spi.display_csb};
            dc_q   <= {dc_q[SYNC_STAGES-2:0], spi.data_commandb};
            sclk_d <= sclk_s;
            csb_d  <= csb_s;
        end
    end

    assign sclk_s   = sclk_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign csb_s    = csb_q[SYNC_STAGES-1];
    assign dc_s     = dc_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_d;
    assign fall     = ~sclk_s & sclk_d;
    assign csb_fall = ~csb_s & csb_d;
    assign csb_rise = csb_s & ~csb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            skip_fall   <= 1'b0;
            push_q      <= 1'b0;
            push_entry  <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            skip_fall   <= skip_fall_n;
            push_q      <= push_n;
            push_entry  <= push_entry_n;
            frame_error <= ferr_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        rx_shift_n   = rx_shift;
        tx_shift_n   = tx_shift;
        skip_fall_n  = skip_fall;
        push_n       = 1'b0;
        push_entry_n = push_entry;
        ferr_n       = 1'b0;
        load         = 1'b0;
        if (csb_rise) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            ferr_n    = (bit_cnt != '0);
        end else begin
            unique case (state)
                S_IDLE: begin
                    bit_cnt_n = '0;
                    if (csb_fall)
                        state_n = S_LOAD;
                end
                S_LOAD: begin
                    load        = 1'b1;
                    skip_fall_n = 1'b0;
                    state_n     = S_SHIFT;
                end
                S_SHIFT: begin
                    if (rise) begin
                        rx_shift_n = {rx_shift[6:0], mosi_s};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n         = '0;
                            push_n            = 1'b1;
                            push_entry_n.dc   = dc_s;
                            push_entry_n.data = {rx_shift[6:0], mosi_s};
                            load              = 1'b1;
                            skip_fall_n       = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else if (fall) begin
                        if (skip_fall)
                            skip_fall_n = 1'b0;
                        else
                            tx_shift_n = {tx_shift[6:0], 1'b0};
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        if (load)
            tx_shift_n = tx_valid ? tx_data : TX_IDLE_BYTE;
    end

    assign tx_ready     = load & tx_valid;
    assign spi.spi_miso = (state == S_SHIFT) & tx_shift[7];

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_entry),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .pop_valid (rx_valid),
        .pop_ready (rx_ready),
        .pop_data  (head)
    );

    assign rx_data = head.data;
    assign rx_dc   = head.dc;

    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (fifo_drop)
            overflow <= 1'b1;
    end

endmodule
